// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults, types and the write-port priority helper used by reg_file_mp
package reg_file_pkg;
    localparam int XLEN_DEF = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF = $clog2(NREGS_DEF);
    localparam int MAX_WR = 4;
    localparam int MAX_AW = 8;
    typedef logic [AW_DEF-1:0] reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xdata_t;
    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } win_t;
    function automatic win_t win_port(
        input logic [MAX_WR-1:0]        wen,
        input logic [MAX_WR*MAX_AW-1:0] waddr,
        input logic [MAX_AW-1:0]        addr
    );
        win_port = '0;
        for (int p = 0; p < MAX_WR; p++)
            if (wen[p] && waddr[p*MAX_AW +: MAX_AW] == addr) begin
                win_port.hit = 1'b1;
                win_port.idx = 2'(p);
            end
    endfunction
endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// reg_scoreboard: per-register busy bits (reserve sets, write clears, reserve wins); busy_vec out
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic [NREGS-1:0] wr_hit,
    output logic [NREGS-1:0] busy_vec
);
    logic [NREGS-1:0] set;
    always_comb begin
        set = '0;
        set[rsv_addr] = rsv_en;
    end
    always_ff @(posedge clk)
        if (!rst_n) busy_vec <= '0;
        else busy_vec <= set | (busy_vec & ~wr_hit);
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with busy scoreboard and bypass; raddr/rdata/rbusy read, wen/waddr/wdata write, rsv_en/rsv_addr reserve, busy_vec
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD = 2,
    parameter int NWR = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS = 1,
    localparam int AW = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic [NREGS-1:0]    busy_vec
);
    logic [MAX_WR-1:0]        wen_pad;
    logic [MAX_WR*MAX_AW-1:0] waddr_pad;
    logic [XLEN-1:0]          wdata_pad [MAX_WR];
    logic [XLEN-1:0]          regs [NREGS];
    logic [NREGS-1:0]         wr_hit;
    logic                     rsv_ok;
    always_comb begin
        wen_pad = '0;
        waddr_pad = '0;
        for (int p = 0; p < MAX_WR; p++) wdata_pad[p] = '0;
        for (int p = 0; p < NWR; p++) begin
            wen_pad[p] = wen[p] && !(ZERO_REG != 0 && waddr[p*AW +: AW] == '0);
            waddr_pad[p*MAX_AW +: MAX_AW] = MAX_AW'(waddr[p*AW +: AW]);
            wdata_pad[p] = wdata[p*XLEN +: XLEN];
        end
    end
    assign rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);
    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        win_t            w;
        logic [XLEN-1:0] q;
        assign w = win_port(wen_pad, waddr_pad, MAX_AW'(i));
        assign wr_hit[i] = w.hit;
        assign regs[i] = q;
        always_ff @(posedge clk)
            if (!rst_n) q <= '0;
            else if (w.hit) q <= wdata_pad[w.idx];
    end
    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [AW-1:0] ra;
        win_t          w;
        logic          zero;
        logic          byp;
        assign ra = raddr[r*AW +: AW];
        assign w = win_port(wen_pad, waddr_pad, MAX_AW'(ra));
        assign zero = ZERO_REG != 0 && ra == '0;
        assign byp = BYPASS != 0 && w.hit;
        assign rdata[r*XLEN +: XLEN] = zero ? '0 : byp ? wdata_pad[w.idx] : regs[ra];
        assign rbusy[r] = !zero && !(byp && !(rsv_ok && rsv_addr == ra)) && busy_vec[ra];
    end
    reg_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .rsv_en   (rsv_ok),
        .rsv_addr (rsv_addr),
        .wr_hit   (wr_hit),
        .busy_vec (busy_vec)
    );
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: table vectors, corner sequences and a random model check for reg_file_mp
module tb_reg_file_mp;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst_n;
    logic [9:0]  raddr, waddr;
    logic [1:0]  wen;
    logic [63:0] wdata;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [63:0] rdata_a, rdata_b;
    logic [1:0]  rbusy_a, rbusy_b;
    logic [31:0] busy_a, busy_b;
    logic [11:0]  raddr_c, waddr_c;
    logic [2:0]   wen_c;
    logic [191:0] wdata_c, rdata_c;
    logic         rsv_en_c;
    logic [3:0]   rsv_addr_c;
    logic [2:0]   rbusy_c;
    logic [15:0]  busy_c;
    int n_cmp = 0;
    int n_bad = 0;
    localparam logic [63:0] PAT = 64'h0101010101010101;

    reg_file_mp #(.BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a),
        .wen(wen), .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_a)
    );
    reg_file_mp #(.BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .wen(wen), .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_b)
    );
    reg_file_mp #(.XLEN(64), .NREGS(16), .NRD(3), .NWR(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .raddr(raddr_c), .rdata(rdata_c), .rbusy(rbusy_c),
        .wen(wen_c), .waddr(waddr_c), .wdata(wdata_c), .rsv_en(rsv_en_c), .rsv_addr(rsv_addr_c), .busy_vec(busy_c)
    );

    typedef struct {
        logic        chk;
        logic        rst_n;
        logic [1:0]  wen;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        rsv;
        logic [4:0]  rsa;
        logic [4:0]  r0, r1;
        logic [31:0] ea0, ea1, eb0;
        logic        eab, ebb;
        logic [31:0] ebv;
    } vec_t;
    vec_t tv [18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] pick();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] m_mem [32];
    logic [31:0] m_busy;

    initial begin
        logic [4:0]  ra;
        logic        hit;
        logic [31:0] val;
        logic        eb;
        logic [3:0]  ca;
        //             chk rst wen wa0 wa1 wd0           wd1           rsv rsa r0 r1 ea0           ea1           eb0           eab ebb ebv
        tv[0]  = '{1'b0, 1'b0, 2'd3, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd5, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        tv[1]  = '{1'b0, 1'b0, 2'd3, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd5, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        tv[2]  = '{1'b1, 1'b1, 2'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        tv[3]  = '{1'b1, 1'b1, 2'd1, 5'd7, 5'd0, 32'h12345678, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h12345678, 32'h12345678, 32'h0, 1'b0, 1'b0, 32'h0};
        tv[4]  = '{1'b1, 1'b1, 2'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h12345678, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 32'h0};
        tv[5]  = '{1'b1, 1'b1, 2'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        tv[6]  = '{1'b1, 1'b1, 2'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        tv[7]  = '{1'b1, 1'b1, 2'd3, 5'd3, 5'd3, 32'hAAAA0000, 32'h0000BBBB, 1'b0, 5'd0, 5'd3, 5'd3, 32'h0000BBBB, 32'h0000BBBB, 32'h0, 1'b0, 1'b0, 32'h0};
        tv[8]  = '{1'b1, 1'b1, 2'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 32'h0000BBBB, 32'h0000BBBB, 32'h0000BBBB, 1'b0, 1'b0, 32'h0};
        tv[9]  = '{1'b1, 1'b1, 2'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        tv[10] = '{1'b1, 1'b1, 2'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h200};
        tv[11] = '{1'b1, 1'b1, 2'd2, 5'd0, 5'd9, 32'h0, 32'h55, 1'b0, 5'd0, 5'd9, 5'd9, 32'h55, 32'h55, 32'h0, 1'b0, 1'b1, 32'h200};
        tv[12] = '{1'b1, 1'b1, 2'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 32'h55, 32'h55, 32'h55, 1'b0, 1'b0, 32'h0};
        tv[13] = '{1'b1, 1'b1, 2'd1, 5'd9, 5'd0, 32'h66, 32'h0, 1'b1, 5'd9, 5'd3, 5'd9, 32'h0000BBBB, 32'h66, 32'h0000BBBB, 1'b0, 1'b0, 32'h0};
        tv[14] = '{1'b1, 1'b1, 2'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 32'h66, 32'h66, 32'h66, 1'b1, 1'b1, 32'h200};
        tv[15] = '{1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        tv[16] = '{1'b1, 1'b1, 2'd1, 5'd9, 5'd0, 32'h77, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 32'h77, 32'h77, 32'h0, 1'b0, 1'b0, 32'h0};
        tv[17] = '{1'b1, 1'b1, 2'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 32'h77, 32'h77, 32'h77, 1'b0, 1'b0, 32'h0};
        wen_c = '0; waddr_c = '0; wdata_c = '0; raddr_c = '0; rsv_en_c = 1'b0; rsv_addr_c = '0;
        for (int k = 0; k < 18; k++) begin
            rst_n = tv[k].rst_n;
            wen = tv[k].wen;
            waddr = {tv[k].wa1, tv[k].wa0};
            wdata = {tv[k].wd1, tv[k].wd0};
            rsv_en = tv[k].rsv;
            rsv_addr = tv[k].rsa;
            raddr = {tv[k].r1, tv[k].r0};
            @(negedge clk);
            if (tv[k].chk) begin
                check($sformatf("vec%0d rdata_a0", k), rdata_a[31:0], tv[k].ea0);
                check($sformatf("vec%0d rdata_a1", k), rdata_a[63:32], tv[k].ea1);
                check($sformatf("vec%0d rdata_b0", k), rdata_b[31:0], tv[k].eb0);
                check($sformatf("vec%0d rbusy_a0", k), rbusy_a[0], tv[k].eab);
                check($sformatf("vec%0d rbusy_b0", k), rbusy_b[0], tv[k].ebb);
                check($sformatf("vec%0d busy_a", k), busy_a, tv[k].ebv);
                check($sformatf("vec%0d busy_b", k), busy_b, tv[k].ebv);
            end
            step();
        end
        wen = '0;
        rsv_en = 1'b0;
        for (int i = 0; i < 16; i += 3) begin
            wen_c = '0;
            for (int p = 0; p < 3; p++)
                if (i + p < 16) begin
                    wen_c[p] = 1'b1;
                    waddr_c[p*4 +: 4] = 4'(i + p);
                    wdata_c[p*64 +: 64] = 64'(i + p) * PAT;
                end
            step();
        end
        wen_c = '0;
        for (int i = 0; i < 16; i++) begin
            for (int r = 0; r < 3; r++) raddr_c[r*4 +: 4] = 4'(i + 5 * r);
            @(negedge clk);
            for (int r = 0; r < 3; r++) begin
                ca = 4'(i + 5 * r);
                check($sformatf("sweep x%0d port%0d", ca, r), rdata_c[r*64 +: 64], 64'(ca) * PAT);
            end
        end
        step();
        wen_c = 3'b111;
        waddr_c = {4'd15, 4'd15, 4'd15};
        wdata_c = {64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
        raddr_c = {4'd0, 4'd14, 4'd15};
        @(negedge clk);
        check("c conflict bypass x15", rdata_c[63:0], 64'h3333333333333333);
        check("c x14 beside conflict", rdata_c[127:64], 64'd14 * PAT);
        step();
        wen_c = 3'b100;
        waddr_c = {4'd0, 4'd0, 4'd0};
        wdata_c = {64'hFFFFFFFFFFFFFFFF, 128'h0};
        rsv_en_c = 1'b1;
        rsv_addr_c = 4'd15;
        raddr_c = {4'd15, 4'd15, 4'd15};
        @(negedge clk);
        for (int r = 0; r < 3; r++)
            check($sformatf("c conflict x15 port%0d", r), rdata_c[r*64 +: 64], 64'h3333333333333333);
        step();
        wen_c = '0;
        rsv_en_c = 1'b0;
        raddr_c = {4'd15, 4'd0, 4'd0};
        @(negedge clk);
        check("c x0 after write", rdata_c[63:0], 64'h0);
        check("c rbusy", rbusy_c, 3'b100);
        check("c busy_vec", busy_c, 16'h8000);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 32; k++) m_mem[k] = '0;
        m_busy = '0;
        for (int n = 0; n < 300; n++) begin
            rst_n = $urandom_range(0, 49) != 0;
            wen = 2'($urandom);
            for (int p = 0; p < 2; p++) begin
                waddr[p*5 +: 5] = pick();
                wdata[p*32 +: 32] = $urandom;
                raddr[p*5 +: 5] = pick();
            end
            rsv_en = $urandom_range(0, 2) == 0;
            rsv_addr = pick();
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                ra = raddr[r*5 +: 5];
                hit = 1'b0;
                val = m_mem[ra];
                for (int p = 0; p < 2; p++)
                    if (wen[p] && waddr[p*5 +: 5] == ra && ra != 0) begin
                        hit = 1'b1;
                        val = wdata[p*32 +: 32];
                    end
                eb = ra != 0 && m_busy[ra];
                check($sformatf("rnd%0d rdata_a%0d", n, r), rdata_a[r*32 +: 32], ra == 0 ? 32'h0 : val);
                check($sformatf("rnd%0d rdata_b%0d", n, r), rdata_b[r*32 +: 32], ra == 0 ? 32'h0 : m_mem[ra]);
                check($sformatf("rnd%0d rbusy_a%0d", n, r), rbusy_a[r], (hit && !(rsv_en && rsv_addr == ra)) ? 1'b0 : eb);
                check($sformatf("rnd%0d rbusy_b%0d", n, r), rbusy_b[r], eb);
            end
            check($sformatf("rnd%0d busy_a", n), busy_a, m_busy);
            check($sformatf("rnd%0d busy_b", n), busy_b, m_busy);
            if (!rst_n) begin
                for (int k = 0; k < 32; k++) m_mem[k] = '0;
                m_busy = '0;
            end else begin
                for (int p = 0; p < 2; p++)
                    if (wen[p] && waddr[p*5 +: 5] != 0) begin
                        m_mem[waddr[p*5 +: 5]] = wdata[p*32 +: 32];
                        m_busy[waddr[p*5 +: 5]] = 1'b0;
                    end
                if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
            end
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
